// File: rtl/ps2_keycode_rx_if.sv
// rtl/ps2_keycode_rx_if.sv - PS/2 pin and keycode bus bundle for ps2_keycode_rx
//
// Purpose
//   Groups the raw PS/2 pins and the decoded keycode outputs into one bundle.
//   The slave modport is the receiver side, which reads the pins and drives
//   the keycode bus. The master modport is the environment side, which drives
//   the pins and consumes the keycode bus.
// Signals
//   ps2_clk    1   raw PS/2 clock from keyboard, asynchronous, idle high
//   ps2_data   1   raw PS/2 data from keyboard, asynchronous, idle high
//   keycode    16  {prior byte, last good byte}
//   key_valid  1   one-cycle pulse on keycode update
//   frame_err  1   one-cycle pulse on parity, stop or timeout error

`timescale 1ns/1ps

interface ps2_keycode_rx_if;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] keycode;
   logic        key_valid;
   logic        frame_err;

   modport master (
      output ps2_clk,
      output ps2_data,
      input  keycode,
      input  key_valid,
      input  frame_err
   );

   modport slave (
      input  ps2_clk,
      input  ps2_data,
      output keycode,
      output key_valid,
      output frame_err
   );
endinterface

// File: rtl/ps2_keycode_rx.sv
// rtl/ps2_keycode_rx.sv - PS/2 keyboard frame receiver producing a 16-bit keycode bus
//
// Purpose
//   The receiver synchronises and deglitches ps2_clk, and it synchronises
//   ps2_data. On each filtered falling edge it steps a start/data/parity/stop
//   state machine. Every good byte is shifted into keycode as
//   {previous byte, latest byte}.
//   A watchdog drops partial frames that stall.
// Parameters
//   FILTER_LEN   consecutive equal samples before the filtered clock follows
//   TIMEOUT_CYC  cycles without a filtered fall before a partial frame is dropped
// Ports
//   clk   in  system clock
//   rst   in  synchronous reset, active-high
//   bus   ps2_keycode_rx_if.slave (ps2_clk, ps2_data in; keycode, key_valid, frame_err out)

`timescale 1ns/1ps

module ps2_keycode_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic                  clk,
   input  logic                  rst,
   ps2_keycode_rx_if.slave       bus
);

   localparam int FW  = $clog2(FILTER_LEN + 1);
   localparam int WDW = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   logic          clk_meta;
   logic          clk_sync;
   logic          dat_meta;
   logic          dat_sync;
   logic          filt_clk;
   logic          filt_clk_d;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   // All conditioning flops are preset high so that the line idles high
   // out of reset and no spurious fall occurs.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta   <= 1'b1;
         clk_sync   <= 1'b1;
         dat_meta   <= 1'b1;
         dat_sync   <= 1'b1;
         filt_clk   <= 1'b1;
         filt_clk_d <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         clk_meta   <= bus.ps2_clk;
         clk_sync   <= clk_meta;
         dat_meta   <= bus.ps2_data;
         dat_sync   <= dat_meta;
         filt_clk_d <= filt_clk;
         // The counter tracks how many consecutive samples disagree with
         // the filtered level. Any agreeing sample restarts it, so a short
         // pulse never reaches the threshold.
         if (clk_sync == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_sync;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   assign fall = filt_clk_d & ~filt_clk;

   // ------------------------------------------------------------------
   // Frame state machine and watchdog
   // ------------------------------------------------------------------
   state_t         state_q,   state_n;
   logic [2:0]     bit_cnt_q, bit_cnt_n;
   logic [7:0]     sh_q,      sh_n;
   logic           par_ok_q,  par_ok_n;
   logic [WDW-1:0] wd_q,      wd_n;
   logic [15:0]    keycode_q, keycode_n;
   logic           key_valid_q, key_valid_n;
   logic           frame_err_q, frame_err_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         sh_q        <= '0;
         par_ok_q    <= 1'b0;
         wd_q        <= '0;
         keycode_q   <= '0;
         key_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         bit_cnt_q   <= bit_cnt_n;
         sh_q        <= sh_n;
         par_ok_q    <= par_ok_n;
         wd_q        <= wd_n;
         keycode_q   <= keycode_n;
         key_valid_q <= key_valid_n;
         frame_err_q <= frame_err_n;
      end
   end

   always_comb begin
      state_n     = state_q;
      bit_cnt_n   = bit_cnt_q;
      sh_n        = sh_q;
      par_ok_n    = par_ok_q;
      wd_n        = wd_q;
      keycode_n   = keycode_q;
      key_valid_n = 1'b0;
      frame_err_n = 1'b0;

      if (fall) begin
         // A fall always wins over a watchdog expiry in the same cycle.
         wd_n = '0;
         case (state_q)
            IDLE: begin
               if (!dat_sync) begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end
            end
            DATA: begin
               // PS/2 sends the LSB first, so each new bit enters at the top.
               sh_n      = {dat_sync, sh_q[7:1]};
               bit_cnt_n = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_n = PARITY;
               end
            end
            PARITY: begin
               par_ok_n = ^{sh_q, dat_sync};
               state_n  = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (dat_sync && par_ok_q) begin
                  keycode_n   = {keycode_q[7:0], sh_q};
                  key_valid_n = 1'b1;
               end else begin
                  frame_err_n = 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end else if (state_q == IDLE) begin
         wd_n = '0;
      end else if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
         state_n     = IDLE;
         bit_cnt_n   = '0;
         wd_n        = '0;
         frame_err_n = 1'b1;
      end else begin
         wd_n = wd_q + WDW'(1);
      end
   end

   assign bus.keycode   = keycode_q;
   assign bus.key_valid = key_valid_q;
   assign bus.frame_err = frame_err_q;

endmodule
